// File: rtl/uiaxis_vid_frame_arb_pkg.sv
// Shared types and defaults for the frame-granular AXIS video arbiter.
// Holds the FSM encoding, channel indices and a saturating drop-count helper.
package uiaxis_vid_frame_arb_pkg;

    typedef enum logic {
        S_SEEK = 1'b0,
        S_PASS = 1'b1
    } state_t;

    localparam int CH0 = 0;
    localparam int CH1 = 1;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_V_LINES = 720;
    localparam int DEF_LCNT_W  = 12;

    // Adds 0..2 discarded beats to the drop counter, pinning at 0xFFFF.
    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [1:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/uiaxis_vid_frame_arb_if.sv
// AXI4-Stream video bundle (tdata/tkeep/tuser/tlast/tvalid/tready).
// master drives the payload and tvalid; slave drives tready.
interface uiaxis_vid_frame_arb_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tuser;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tkeep, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/uiaxis_rr_arb2.sv
// Two-request round-robin picker, purely combinational.
// Ports: req[1:0] requests, last index of the previous winner, gnt one-hot.
module uiaxis_rr_arb2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        // On a tie, favour whichever channel did not win last time.
        if (req == 2'b11) begin
            gnt = last[0] ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/uiaxis_vid_frame_arb.sv
// Frame-granular 2:1 AXIS video arbiter; grant only moves at frame boundaries.
// Ports: vid_clk_i/vid_rst_i, ch_en_i, s0_axis/s1_axis in, m_axis_vid out,
//        grant_o, frame_done_o, frame_err_o, drop_cnt_o (saturating).
module uiaxis_vid_frame_arb
    import uiaxis_vid_frame_arb_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int V_LINES        = DEF_V_LINES,
    parameter int LCNT_W         = DEF_LCNT_W,
    parameter int DROP_UNGRANTED = 1
) (
    input  logic                   vid_clk_i,
    input  logic                   vid_rst_i,
    input  logic [1:0]             ch_en_i,
    uiaxis_vid_frame_arb_if.slave  s0_axis,
    uiaxis_vid_frame_arb_if.slave  s1_axis,
    uiaxis_vid_frame_arb_if.master m_axis_vid,
    output logic [1:0]             grant_o,
    output logic                   frame_done_o,
    output logic                   frame_err_o,
    output logic [15:0]            drop_cnt_o
);

    localparam logic              DROP      = (DROP_UNGRANTED != 0);
    localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(V_LINES - 1);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_q, last_d;
    logic [LCNT_W-1:0]   line_q, line_d;
    logic                first_q, first_d;
    logic [15:0]         drop_q, drop_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [1:0]          vld, usr, rdy, drop_hit, cand, pick;
    logic                sel, is_pass;
    logic                g_vld, g_usr, g_lst, acc;
    logic [DATA_W-1:0]   g_data;
    logic [DATA_W/8-1:0] g_keep;

    assign vld[CH0] = s0_axis.tvalid;
    assign vld[CH1] = s1_axis.tvalid;
    assign usr[CH0] = s0_axis.tuser;
    assign usr[CH1] = s1_axis.tuser;

    // Only enabled channels sitting on a start-of-frame may compete.
    assign cand = ch_en_i & vld & usr;

    uiaxis_rr_arb2 u_rr (
        .req  (cand),
        .last (last_q),
        .gnt  (pick)
    );

    assign sel     = grant_q[CH1];
    assign is_pass = (state_q == S_PASS);

    assign g_vld  = sel ? vld[CH1] : vld[CH0];
    assign g_usr  = sel ? usr[CH1] : usr[CH0];
    assign g_lst  = sel ? s1_axis.tlast : s0_axis.tlast;
    assign g_data = sel ? s1_axis.tdata : s0_axis.tdata;
    assign g_keep = sel ? s1_axis.tkeep : s0_axis.tkeep;

    assign m_axis_vid.tdata  = g_data;
    assign m_axis_vid.tkeep  = g_keep;
    assign m_axis_vid.tuser  = g_usr;
    assign m_axis_vid.tlast  = g_lst;
    assign m_axis_vid.tvalid = is_pass & g_vld & ~vid_rst_i;

    assign acc = m_axis_vid.tvalid & m_axis_vid.tready;

    always_comb begin
        rdy      = '0;
        drop_hit = '0;
        for (int c = 0; c < 2; c++) begin
            if (vid_rst_i) begin
                rdy[c] = 1'b0;
            end else if (is_pass && grant_q[c]) begin
                rdy[c] = m_axis_vid.tready;
            end else if (!is_pass && ch_en_i[c]) begin
                // Drain mid-frame beats, hold the SOF for the pass phase.
                rdy[c] = vld[c] & ~usr[c];
            end else begin
                rdy[c] = DROP;
            end
            drop_hit[c] = vld[c] & rdy[c] & ~(is_pass & grant_q[c]);
        end
    end

    assign s0_axis.tready = rdy[CH0];
    assign s1_axis.tready = rdy[CH1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        line_d  = line_q;
        first_d = first_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        drop_d  = sat_add16(drop_q,
                            {1'b0, drop_hit[0]} + {1'b0, drop_hit[1]});
        unique case (state_q)
            S_SEEK: begin
                if (|pick) begin
                    state_d = S_PASS;
                    grant_d = pick;
                    first_d = 1'b1;
                    line_d  = '0;
                end
            end
            S_PASS: begin
                if (acc) begin
                    first_d = 1'b0;
                    if (g_usr && !first_q) begin
                        // Restarted frame: recount from this SOF.
                        err_d  = 1'b1;
                        line_d = g_lst ? LCNT_W'(1) : '0;
                    end else if (g_lst) begin
                        if (line_q == LAST_LINE) begin
                            done_d  = 1'b1;
                            last_d  = sel;
                            state_d = S_SEEK;
                            grant_d = '0;
                            line_d  = '0;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge vid_clk_i) begin
        if (vid_rst_i) begin
            state_q <= S_SEEK;
            grant_q <= '0;
            last_q  <= 1'b1;
            line_q  <= '0;
            first_q <= 1'b1;
            drop_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            line_q  <= line_d;
            first_q <= first_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign grant_o      = grant_q;
    assign frame_done_o = done_q & ~vid_rst_i;
    assign frame_err_o  = err_q & ~vid_rst_i;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_uiaxis_vid_frame_arb.sv
// Self-checking bench for uiaxis_vid_frame_arb: queue-based sources,
// output capture, and a frame-level expectation model.
module tb_uiaxis_vid_frame_arb;
    import uiaxis_vid_frame_arb_pkg::*;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int VL = 4;
    localparam int LW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b00;
    logic [1:0]  en [2];
    logic [3:0]  vld = '0;
    logic [3:0]  fire = '0;
    logic [3:0]  rdy;
    logic [1:0]  mrdy = 2'b11;
    logic [1:0]  mv;
    logic [1:0]  done, err;
    logic [1:0]  gnt [2];
    logic [15:0] dcnt [2];
    beat_t       drv [4];
    beat_t       mb [2];

    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) a_s0 ();
    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) a_s1 ();
    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) a_m ();
    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) b_s0 ();
    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) b_s1 ();
    uiaxis_vid_frame_arb_if #(.DATA_W(DW)) b_m ();

    assign {a_s0.tdata, a_s0.tkeep, a_s0.tuser, a_s0.tlast} = drv[0];
    assign {a_s1.tdata, a_s1.tkeep, a_s1.tuser, a_s1.tlast} = drv[1];
    assign {b_s0.tdata, b_s0.tkeep, b_s0.tuser, b_s0.tlast} = drv[2];
    assign {b_s1.tdata, b_s1.tkeep, b_s1.tuser, b_s1.tlast} = drv[3];
    assign a_s0.tvalid = vld[0];
    assign a_s1.tvalid = vld[1];
    assign b_s0.tvalid = vld[2];
    assign b_s1.tvalid = vld[3];
    assign rdy = {b_s1.tready, b_s0.tready, a_s1.tready, a_s0.tready};
    assign a_m.tready = mrdy[0];
    assign b_m.tready = mrdy[1];
    assign mv = {b_m.tvalid, a_m.tvalid};
    assign mb[0] = {a_m.tdata, a_m.tkeep, a_m.tuser, a_m.tlast};
    assign mb[1] = {b_m.tdata, b_m.tkeep, b_m.tuser, b_m.tlast};

    uiaxis_vid_frame_arb #(
        .DATA_W(DW), .V_LINES(VL), .LCNT_W(LW), .DROP_UNGRANTED(1)
    ) dut_a (
        .vid_clk_i(clk), .vid_rst_i(rst[0]), .ch_en_i(en[0]),
        .s0_axis(a_s0), .s1_axis(a_s1), .m_axis_vid(a_m),
        .grant_o(gnt[0]), .frame_done_o(done[0]),
        .frame_err_o(err[0]), .drop_cnt_o(dcnt[0])
    );

    uiaxis_vid_frame_arb #(
        .DATA_W(DW), .V_LINES(VL), .LCNT_W(LW), .DROP_UNGRANTED(0)
    ) dut_b (
        .vid_clk_i(clk), .vid_rst_i(rst[1]), .ch_en_i(en[1]),
        .s0_axis(b_s0), .s1_axis(b_s1), .m_axis_vid(b_m),
        .grant_o(gnt[1]), .frame_done_o(done[1]),
        .frame_err_o(err[1]), .drop_cnt_o(dcnt[1])
    );

    beat_t srcq [4][$];
    beat_t outq [2][$];
    beat_t expq [$];
    beat_t frm [$];
    int    done_n [2];
    int    err_n [2];
    int    done_at [2];
    int    err_at [2];
    int    mirror_bad = 0;
    int    b1_rdy_hi = 0;
    int    rdy_pct = 100;
    int    tests_run = 0;
    int    tests_failed = 0;

    // Sources present queue heads; handshakes sampled 1 ns before posedge.
    always begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            vld[i] = (srcq[i].size() > 0);
            drv[i] = vld[i] ? srcq[i][0] : '0;
        end
        for (int d = 0; d < 2; d++) begin
            mrdy[d] = ($urandom_range(0, 99) < rdy_pct);
        end
        #4;
        fire = vld & rdy;
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) begin
                done_n[d]++;
                done_at[d] = outq[d].size();
            end
            if (err[d] === 1'b1) begin
                err_n[d]++;
                err_at[d] = outq[d].size();
            end
            if (mv[d] && mrdy[d]) outq[d].push_back(mb[d]);
        end
        if (!rst[0] && gnt[0] == 2'b01 && rdy[0] !== mrdy[0]) mirror_bad++;
        if (rdy[3] !== 1'b0) b1_rdy_hi++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mk_frame(input int nl, input int bpl, input bit sof);
        beat_t b;
        frm.delete();
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < bpl; k++) begin
                b.data = $urandom;
                b.keep = KW'($urandom);
                b.user = sof && (l == 0) && (k == 0);
                b.last = (k == bpl - 1);
                frm.push_back(b);
            end
        end
    endtask

    task automatic push_src(input int dc, input bit to_exp);
        foreach (frm[i]) begin
            srcq[dc].push_back(frm[i]);
            if (to_exp) expq.push_back(frm[i]);
        end
    endtask

    task automatic do_reset(input int d, input bit clr);
        @(negedge clk);
        rst[d] = 1'b1;
        if (clr) begin
            srcq[2*d].delete();
            srcq[2*d+1].delete();
        end
        @(negedge clk);
        #2;
        chk("rst grant", 64'(gnt[d]), 64'd0);
        chk("rst m_tvalid", 64'(mv[d]), 64'd0);
        chk("rst s_tready", 64'({rdy[2*d+1], rdy[2*d]}), 64'd0);
        chk("rst drop_cnt", 64'(dcnt[d]), 64'd0);
        chk("rst done/err", 64'({done[d], err[d]}), 64'd0);
    endtask

    task automatic rel_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b0;
        outq[d].delete();
        done_n[d] = 0;
        err_n[d]  = 0;
        done_at[d] = -1;
        err_at[d]  = -1;
    endtask

    task automatic wait_idle(input int d, input logic [1:0] mask,
                             input string tag);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (n < 2000 && !idle) begin
            @(negedge clk);
            #2;
            n++;
            idle = (!mask[0] || srcq[2*d].size() == 0) &&
                   (!mask[1] || srcq[2*d+1].size() == 0) &&
                   (gnt[d] == 2'b00);
        end
        chk({tag, " idle"}, 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic cmp_out(input int d, input string tag);
        int bad;
        bad = 0;
        chk({tag, " beats"}, 64'(outq[d].size()), 64'(expq.size()));
        for (int i = 0; i < outq[d].size() && i < expq.size(); i++) begin
            if (outq[d][i] !== expq[i]) bad++;
        end
        chk({tag, " data"}, 64'(bad), 64'd0);
    endtask

    int model_last, win, exp_drop, bpl, rem, nu, nl;

    initial begin
        en[0] = 2'b11;
        en[1] = 2'b11;

        // One 4-line frame on ch0
        do_reset(0, 1'b1);
        rel_reset(0);
        expq.delete();
        mk_frame(VL, 8, 1'b1);
        push_src(0, 1'b1);
        repeat (4) @(negedge clk);
        #2;
        chk("s1 grant mid", 64'(gnt[0]), 64'd1);
        wait_idle(0, 2'b11, "s1");
        cmp_out(0, "s1");
        nu = 0;
        nl = 0;
        foreach (outq[0][i]) begin
            nu += int'(outq[0][i].user);
            nl += int'(outq[0][i].last);
        end
        chk("s1 tuser count", 64'(nu), 64'd1);
        chk("s1 tlast count", 64'(nl), 64'(VL));
        chk("s1 done count", 64'(done_n[0]), 64'd1);
        chk("s1 err count", 64'(err_n[0]), 64'd0);
        chk("s1 grant end", 64'(gnt[0]), 64'd0);
        chk("s1 drop", 64'(dcnt[0]), 64'd0);

        // Both channels offer SOF together for 3 frames
        do_reset(0, 1'b1);
        rel_reset(0);
        expq.delete();
        model_last = 1;
        exp_drop = 0;
        for (int f = 0; f < 3; f++) begin
            win = (model_last == 1) ? 0 : 1;
            for (int c = 0; c < 2; c++) begin
                mk_frame(VL, 8, 1'b1);
                push_src(c, c == win);
                if (c != win) exp_drop += frm.size();
            end
            model_last = win;
        end
        wait_idle(0, 2'b11, "s2");
        cmp_out(0, "s2");
        chk("s2 done count", 64'(done_n[0]), 64'd3);
        chk("s2 drop", 64'(dcnt[0]), 64'(exp_drop));

        // ch1 joins mid-line, 5 junk beats before its SOF
        do_reset(0, 1'b1);
        rel_reset(0);
        expq.delete();
        mk_frame(1, 5, 1'b0);
        push_src(1, 1'b0);
        mk_frame(VL, 6, 1'b1);
        push_src(1, 1'b1);
        wait_idle(0, 2'b11, "s3");
        cmp_out(0, "s3");
        chk("s3 drop", 64'(dcnt[0]), 64'd5);
        chk("s3 first tuser",
            64'(outq[0].size() > 0 ? outq[0][0].user : 1'b0), 64'd1);

        // Random downstream backpressure, ch0 only
        do_reset(0, 1'b1);
        rel_reset(0);
        expq.delete();
        mirror_bad = 0;
        rdy_pct = 50;
        for (int f = 0; f < 3; f++) begin
            mk_frame(VL, $urandom_range(2, 9), 1'b1);
            push_src(0, 1'b1);
        end
        wait_idle(0, 2'b11, "s4");
        rdy_pct = 100;
        cmp_out(0, "s4");
        chk("s4 done count", 64'(done_n[0]), 64'd3);
        chk("s4 tready mirror", 64'(mirror_bad), 64'd0);
        chk("s4 drop", 64'(dcnt[0]), 64'd0);

        // Frame restarted after 2 lines
        do_reset(0, 1'b1);
        rel_reset(0);
        expq.delete();
        bpl = $urandom_range(3, 8);
        mk_frame(2, bpl, 1'b1);
        push_src(0, 1'b1);
        mk_frame(VL, bpl, 1'b1);
        push_src(0, 1'b1);
        wait_idle(0, 2'b11, "s5");
        cmp_out(0, "s5");
        chk("s5 err count", 64'(err_n[0]), 64'd1);
        chk("s5 err position", 64'(err_at[0]), 64'(2 * bpl + 1));
        chk("s5 done count", 64'(done_n[0]), 64'd1);
        chk("s5 done position", 64'(done_at[0]), 64'((2 + VL) * bpl));

        // No-drop variant, ch1 disabled
        do_reset(1, 1'b1);
        en[1] = 2'b01;
        rel_reset(1);
        expq.delete();
        b1_rdy_hi = 0;
        mk_frame(VL, 5, 1'b1);
        push_src(3, 1'b0);
        mk_frame(VL, 5, 1'b1);
        push_src(2, 1'b1);
        wait_idle(1, 2'b01, "s6");
        cmp_out(1, "s6");
        chk("s6 ch1 untouched", 64'(srcq[3].size()), 64'(VL * 5));
        chk("s6 ch1 tready", 64'(b1_rdy_hi), 64'd0);
        chk("s6 drop", 64'(dcnt[1]), 64'd0);
        chk("s6 done count", 64'(done_n[1]), 64'd1);

        // Reset in the middle of a frame
        mk_frame(VL, 5, 1'b1);
        push_src(2, 1'b0);
        repeat (9) @(negedge clk);
        do_reset(1, 1'b0);
        rem = srcq[2].size();
        chk("s6 rem nonzero", 64'(rem > 0 && rem < VL * 5), 64'd1);
        rel_reset(1);
        #2;
        chk("s6 post m_tvalid", 64'(mv[1]), 64'd0);
        chk("s6 post grant", 64'(gnt[1]), 64'd0);
        wait_idle(1, 2'b01, "s6b");
        chk("s6 drained", 64'(dcnt[1]), 64'(rem));
        chk("s6 no output", 64'(outq[1].size()), 64'd0);
        chk("s6 ch1 tready end", 64'(b1_rdy_hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
